// File: rtl/compare_pipe.sv
// Registered unsigned/signed comparator with running min/max of a and saturating
// gt/eq/lt counters. Statistics follow a two-state tracker that latches the compare mode.
module compare_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   input  logic             clr,
   output logic             out_valid,
   output logic [2:0]       flag,
   output logic [2:0]       flag_s,
   output logic [WIDTH-1:0] min_a,
   output logic [WIDTH-1:0] max_a,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt
);

   typedef enum logic {EMPTY, TRACK} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t     state;
   logic       mode;
   logic [2:0] fu, fs, sel;
   logic       first, md, a_lt_min, a_gt_max;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      return (en && c != CNT_MAX) ? c + 1'b1 : c;
   endfunction

   always_comb begin
      fu = {a > b, a == b, a < b};
      fs = {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
      // A clear coinciding with a sample restarts tracking on that sample.
      first = (state == EMPTY) || clr;
      md = first ? is_signed : mode;
      sel = md ? fs : fu;
      a_lt_min = md ? ($signed(a) < $signed(min_a)) : (a < min_a);
      a_gt_max = md ? ($signed(a) > $signed(max_a)) : (a > max_a);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         mode      <= 1'b0;
         out_valid <= 1'b0;
         flag      <= '0;
         flag_s    <= '0;
         min_a     <= '0;
         max_a     <= '0;
         gt_cnt    <= '0;
         eq_cnt    <= '0;
         lt_cnt    <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            flag   <= fu;
            flag_s <= fs;
            if (first) begin
               state  <= TRACK;
               mode   <= is_signed;
               min_a  <= a;
               max_a  <= a;
               gt_cnt <= CNT_W'(sel[2]);
               eq_cnt <= CNT_W'(sel[1]);
               lt_cnt <= CNT_W'(sel[0]);
            end else begin
               if (a_lt_min) min_a <= a;
               if (a_gt_max) max_a <= a;
               gt_cnt <= sat_inc(gt_cnt, sel[2]);
               eq_cnt <= sat_inc(eq_cnt, sel[1]);
               lt_cnt <= sat_inc(lt_cnt, sel[0]);
            end
         end else if (clr) begin
            state  <= EMPTY;
            min_a  <= '0;
            max_a  <= '0;
            gt_cnt <= '0;
            eq_cnt <= '0;
            lt_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_compare_pipe.sv
// Directed bench for compare_pipe: a reference model pushes expected outputs per cycle
// into a queue, which is popped and compared one cycle later against the DUT.
module tb_compare_pipe;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] a = '0, b = '0;
   logic             is_signed = 1'b0;
   logic             clr = 1'b0;
   logic             out_valid;
   logic [2:0]       flag, flag_s;
   logic [WIDTH-1:0] min_a, max_a;
   logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

   compare_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .is_signed(is_signed),
      .clr(clr), .out_valid(out_valid), .flag(flag), .flag_s(flag_s), .min_a(min_a),
      .max_a(max_a), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic             ov;
      logic [2:0]       f, fs;
      logic [WIDTH-1:0] mn, mx;
      logic [CNT_W-1:0] g, e, l;
   } exp_t;

   exp_t q[$];
   int checks = 0, passes = 0;

   // reference model state
   logic             m_track = 1'b0, m_mode = 1'b0;
   exp_t             m;

   function automatic logic [2:0] cmp(input logic [WIDTH-1:0] x, y, input logic sgn);
      logic [WIDTH-1:0] bias, xb, yb;
      bias = '0;
      bias[WIDTH-1] = sgn;         // offset-binary trick turns signed order into unsigned
      xb = x ^ bias;
      yb = y ^ bias;
      if (xb > yb) return 3'b100;
      if (xb == yb) return 3'b010;
      return 3'b001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step(input logic r, v, input logic [WIDTH-1:0] xa, xb,
                       input logic s, c);
      exp_t got, e;
      logic [2:0] sel;
      logic md;
      rst = r; in_valid = v; a = xa; b = xb; is_signed = s; clr = c;
      if (r) begin
         m = '{default: '0};
         m_track = 1'b0; m_mode = 1'b0;
      end else begin
         m.ov = v;
         if (v) begin
            m.f  = cmp(xa, xb, 1'b0);
            m.fs = cmp(xa, xb, 1'b1);
            md   = (!m_track || c) ? s : m_mode;
            sel  = md ? m.fs : m.f;
            if (!m_track || c) begin
               m_track = 1'b1; m_mode = s;
               m.mn = xa; m.mx = xa;
               m.g = {1'b0, sel[2]}; m.e = {1'b0, sel[1]}; m.l = {1'b0, sel[0]};
            end else begin
               if (cmp(xa, m.mn, md) == 3'b001) m.mn = xa;
               if (cmp(xa, m.mx, md) == 3'b100) m.mx = xa;
               if (sel[2] && m.g != 2'd3) m.g = m.g + 2'd1;
               if (sel[1] && m.e != 2'd3) m.e = m.e + 2'd1;
               if (sel[0] && m.l != 2'd3) m.l = m.l + 2'd1;
            end
         end else if (c) begin
            m_track = 1'b0;
            m.mn = '0; m.mx = '0; m.g = '0; m.e = '0; m.l = '0;
         end
      end
      q.push_back(m);
      @(posedge clk);
      #1;
      e = q.pop_front();
      got = '{out_valid, flag, flag_s, min_a, max_a, gt_cnt, eq_cnt, lt_cnt};
      chk("out_valid", 32'(got.ov), 32'(e.ov));
      chk("flag",      32'(got.f),  32'(e.f));
      chk("flag_s",    32'(got.fs), 32'(e.fs));
      chk("min_a",     32'(got.mn), 32'(e.mn));
      chk("max_a",     32'(got.mx), 32'(e.mx));
      chk("gt_cnt",    32'(got.g),  32'(e.g));
      chk("eq_cnt",    32'(got.e),  32'(e.e));
      chk("lt_cnt",    32'(got.l),  32'(e.l));
   endtask

   initial begin
      m = '{default: '0};
      // reset
      step(1, 0, 8'h00, 8'h00, 0, 0);
      step(1, 1, 8'h12, 8'h34, 0, 0);
      chk("rst_flag", 32'(flag), 32'h0);
      // T1
      step(0, 1, 8'h23, 8'h23, 0, 0);
      chk("t1_ov", 32'(out_valid), 32'h1);
      chk("t1_flag", 32'(flag), 32'h2);
      chk("t1_flag_s", 32'(flag_s), 32'h2);
      // T2
      step(0, 1, 8'hAB, 8'h23, 0, 0);
      chk("t2a_flag", 32'(flag), 32'h4);
      chk("t2a_flag_s", 32'(flag_s), 32'h1);
      step(0, 1, 8'h23, 8'hAB, 0, 0);
      chk("t2b_flag", 32'(flag), 32'h1);
      chk("t2b_flag_s", 32'(flag_s), 32'h4);
      step(0, 1, 8'hAB, 8'hAF, 0, 0);
      chk("t2c_flag", 32'(flag), 32'h1);
      chk("t2c_flag_s", 32'(flag_s), 32'h1);
      // flags hold while idle
      step(0, 0, 8'h00, 8'h00, 0, 0);
      chk("hold_flag", 32'(flag), 32'h1);
      // T3 signed, is_signed toggled mid-stream
      step(0, 0, 8'h00, 8'h00, 0, 1);
      step(0, 1, 8'h23, 8'h00, 1, 0);
      step(0, 1, 8'hAB, 8'h00, 0, 0);
      step(0, 1, 8'h46, 8'h00, 0, 0);
      chk("t3s_min", 32'(min_a), 32'hAB);
      chk("t3s_max", 32'(max_a), 32'h46);
      // T3 unsigned
      step(0, 0, 8'h00, 8'h00, 0, 1);
      step(0, 1, 8'h23, 8'h00, 0, 0);
      step(0, 1, 8'hAB, 8'h00, 1, 0);
      step(0, 1, 8'h46, 8'h00, 1, 0);
      chk("t3u_min", 32'(min_a), 32'h23);
      chk("t3u_max", 32'(max_a), 32'hAB);
      // T4 saturation
      step(0, 0, 8'h00, 8'h00, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 8'h10, 8'h10, 0, 0);
      chk("t4_eq", 32'(eq_cnt), 32'h3);
      chk("t4_gt", 32'(gt_cnt), 32'h0);
      // random mix, occasional clears
      for (int i = 0; i < 40; i++)
         step(0, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
              1'($urandom), ($urandom_range(0, 9) == 0));
      // T5
      step(0, 1, 8'h05, 8'h07, 0, 1);
      chk("t5_min", 32'(min_a), 32'h05);
      chk("t5_max", 32'(max_a), 32'h05);
      chk("t5_lt", 32'(lt_cnt), 32'h1);
      chk("t5_flag", 32'(flag), 32'h1);
      step(0, 0, 8'h00, 8'h00, 0, 1);
      chk("t5_clr", 32'({min_a, max_a, gt_cnt, eq_cnt, lt_cnt}), 32'h0);
      // T6 reset mid-stream
      step(0, 1, 8'h11, 8'h22, 0, 0);
      step(1, 1, 8'h33, 8'h22, 0, 0);
      chk("t6_ov", 32'(out_valid), 32'h0);
      step(0, 1, 8'h46, 8'h10, 0, 0);
      chk("t6_min", 32'(min_a), 32'h46);
      chk("t6_max", 32'(max_a), 32'h46);
      step(0, 0, 8'h00, 8'h00, 0, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
